vga_ball_engine: RTL

- Parametrised ball-motion and pixel-render engine for the breakout playfield.
- Owns ball position and direction, updated once per frame at the start of vertical blanking.
- Bounces off the three walls, the paddle and bricks; reports a miss when the ball exits the bottom.
- Sits between the VGA sync generator (pixel coordinates in) and the pixel colour mux (ball_on out).

---
 rtl/vga_ball_engine.sv | 134 +++++++++++++
 1 files changed

// File: rtl/vga_ball_engine.sv
// vga_ball_engine: breakout ball motion (one step per frame) and ball pixel render.
// Define VGA_BALL_ROUND_EN to render a round ball; collision geometry stays square.
module vga_ball_engine #(
   parameter int H_ACTIVE  = 640,
   parameter int V_ACTIVE  = 480,
   parameter int BALL_SIZE = 10,
   parameter int SPEED     = 2,
   parameter int PADDLE_Y  = 450,
   parameter int PADDLE_W  = 64
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       pixel_tick,
   input  logic [9:0] pixel_x,
   input  logic [9:0] pixel_y,
   input  logic [9:0] paddle_x,
   input  logic       launch,
   input  logic       brick_hit,
   output logic       ball_on,
   output logic [9:0] ball_x,
   output logic [9:0] ball_y,
   output logic       paddle_hit,
   output logic       miss
);
   localparam logic [10:0] XMAX     = 11'(H_ACTIVE - BALL_SIZE);
   localparam logic [10:0] SPD      = 11'(SPEED);
   localparam logic [10:0] BS       = 11'(BALL_SIZE);
   localparam logic [10:0] BS1      = 11'(BALL_SIZE - 1);
   localparam logic [10:0] PY       = 11'(PADDLE_Y);
   localparam logic [10:0] PW1      = 11'(PADDLE_W - 1);
   localparam logic [10:0] VA       = 11'(V_ACTIVE);
   localparam logic [10:0] HALFPAD  = 11'(PADDLE_W / 2);
   localparam logic [10:0] HALFBALL = 11'(BALL_SIZE / 2);
   localparam logic [9:0]  XREST    = 10'((H_ACTIVE - BALL_SIZE) / 2);
   localparam logic [9:0]  YREST    = 10'(PADDLE_Y - BALL_SIZE);

   typedef enum logic [1:0] {IDLE, MOVE, MISS} stateType;

   stateType    state;
   logic        dirRight, dirUp, brickFlag;
   logic        frameTick, upEff, nextRight, nextUp, padHit, ballLost, inBox, shapeOk;
   logic [10:0] bx, by, px, py, xPlus, yDown, padCenter, idleRaw;
   logic [9:0]  nx, ny, idleX;

   assign frameTick = pixel_tick && pixel_x == 10'd0 && pixel_y == 10'(V_ACTIVE);

   // next-frame position and direction; 11-bit sums so edge tests never wrap
   always_comb begin
      bx = {1'b0, ball_x};
      by = {1'b0, ball_y};
      px = {1'b0, pixel_x};
      py = {1'b0, pixel_y};
      upEff = brickFlag ? !dirUp : dirUp;
      xPlus = bx + SPD;
      nx = dirRight ? (xPlus > XMAX ? XMAX[9:0] : xPlus[9:0]) : (bx < SPD ? 10'd0 : ball_x - SPD[9:0]);
      nextRight = dirRight ? xPlus <= XMAX : bx < SPD;
      yDown = by + SPD;
      padHit = !upEff && by + BS1 < PY && yDown + BS1 >= PY
               && {1'b0, nx} + BS1 >= {1'b0, paddle_x} && {1'b0, nx} <= {1'b0, paddle_x} + PW1;
      ballLost = !upEff && !padHit && yDown + BS > VA;
      ny = upEff ? (by < SPD ? 10'd0 : ball_y - SPD[9:0]) : padHit ? YREST : ballLost ? ball_y : yDown[9:0];
      nextUp = upEff ? by >= SPD : padHit;
      padCenter = {1'b0, paddle_x} + HALFPAD;
      idleRaw = padCenter < HALFBALL ? 11'd0 : padCenter - HALFBALL;
      idleX = idleRaw > XMAX ? XMAX[9:0] : idleRaw[9:0];
      inBox = px >= bx && px <= bx + BS1 && py >= by && py <= by + BS1;
   end

`ifdef VGA_BALL_ROUND_EN
   logic [10:0] twoDx, twoDy, ax, ay;
   logic [11:0] sqx, sqy;

   // circle test relative to the ball centre, doubled to stay in integers
   always_comb begin
      twoDx = (px - bx) << 1;
      twoDy = (py - by) << 1;
      ax = twoDx >= BS1 ? twoDx - BS1 : BS1 - twoDx;
      ay = twoDy >= BS1 ? twoDy - BS1 : BS1 - twoDy;
      sqx = 12'(ax) * 12'(ax);
      sqy = 12'(ay) * 12'(ay);
      shapeOk = sqx + sqy <= 12'(BALL_SIZE * BALL_SIZE);
   end
`else
   assign shapeOk = 1'b1;
`endif

   // game state machine; ball moves only on the frame tick
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         ball_x <= XREST;
         ball_y <= YREST;
         dirRight <= 1'b1;
         dirUp <= 1'b1;
         brickFlag <= 1'b0;
         paddle_hit <= 1'b0;
         miss <= 1'b0;
      end else begin
         paddle_hit <= 1'b0;
         miss <= 1'b0;
         brickFlag <= brick_hit || (brickFlag && !(state == MOVE && frameTick));
         case (state)
            IDLE: begin
               if (frameTick) begin
                  ball_x <= idleX;
                  ball_y <= YREST;
                  dirRight <= 1'b1;
                  dirUp <= 1'b1;
               end
               if (launch) state <= MOVE;
            end
            MOVE: if (frameTick) begin
               ball_x <= nx;
               ball_y <= ny;
               dirRight <= nextRight;
               dirUp <= nextUp;
               paddle_hit <= padHit;
               if (ballLost) begin
                  state <= MISS;
                  miss <= 1'b1;
               end
            end
            MISS: if (frameTick) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   // ball pixel flag, registered on the pixel enable so it trails the scan by one clock
   always_ff @(posedge clock or posedge reset) begin
      if (reset) ball_on <= 1'b0;
      else if (pixel_tick) ball_on <= inBox && shapeOk && state != MISS;
   end
endmodule
